// File: rtl/board_renderer_pkg.sv
// Shared definitions for the board renderer family: cell codes, palette and FSM states.
// Also hosts a small width helper used wherever an index needs at least one bit.
package board_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_O     = 2'd1;
    localparam logic [1:0] CELL_X     = 2'd2;
    localparam logic [1:0] CELL_RSVD  = 2'd3;

    localparam logic [2:0] COL_WHITE  = 3'b111;
    localparam logic [2:0] COL_LBLUE  = 3'b011;
    localparam logic [2:0] COL_PURPLE = 3'b101;
    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_CURSOR = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_DONE
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/board_renderer_if.sv
// Request/plot bundle between a board renderer and its client (game logic + VGA adapter).
// The master drives the render request; the slave (renderer) drives status and the pixel stream.
interface board_renderer_if #(
    parameter int N  = 3,
    parameter int XW = 8,
    parameter int YW = 7
);
    localparam int IW = board_pkg::idx_width(N * N);

    logic              start;
    logic [2*N*N-1:0]  grid;
    logic              cursor_en;
    logic [IW-1:0]     cursor_idx;
    logic              busy;
    logic              done;
    logic [XW-1:0]     x_out;
    logic [YW-1:0]     y_out;
    logic [2:0]        colour_out;
    logic              plot;

    modport master (
        output start, grid, cursor_en, cursor_idx,
        input  busy, done, x_out, y_out, colour_out, plot
    );

    modport slave (
        input  start, grid, cursor_en, cursor_idx,
        output busy, done, x_out, y_out, colour_out, plot
    );

endinterface

// File: rtl/board_renderer_cell_colour_lut.sv
// Maps a 2-bit cell code to its 3-bit VGA colour; shared with other sprite renderers.
module cell_colour_lut
    import board_pkg::*;
(
    input  logic [1:0] code,
    output logic [2:0] colour
);

    always_comb begin
        colour = COL_BLACK;
        case (code)
            CELL_EMPTY: colour = COL_WHITE;
            CELL_O:     colour = COL_LBLUE;
            CELL_X:     colour = COL_PURPLE;
            CELL_RSVD:  colour = COL_BLACK;
            default:    colour = COL_BLACK;
        endcase
    end

endmodule

// File: rtl/board_renderer.sv
// Sweeps a snapshot of an N x N board and streams one filled square per cell, one pixel per cycle.
// The pixel emitted on each edge is computed from the "next" counters, so every output is registered.
module board_renderer
    import board_pkg::*;
#(
    parameter int N       = 3,
    parameter int CELL_PX = 20,
    parameter int PITCH   = 30,
    parameter int X0      = 37,
    parameter int Y0      = 7,
    parameter int XW      = 8,
    parameter int YW      = 7
) (
    input  logic             clock,
    input  logic             resetn,
    board_renderer_if.slave  bus
);

    localparam int NN = N * N;
    localparam int GW = 2 * NN;
    localparam int KW = idx_width(NN);
    localparam int CW = idx_width(N);
    localparam int PW = idx_width(CELL_PX);

    if (X0 + (N - 1) * PITCH + CELL_PX - 1 >= (1 << XW)) begin : g_x_range
        $error("board_renderer: board does not fit in XW bits of x");
    end
    if (Y0 + (N - 1) * PITCH + CELL_PX - 1 >= (1 << YW)) begin : g_y_range
        $error("board_renderer: board does not fit in YW bits of y");
    end
    if (PITCH < CELL_PX) begin : g_pitch
        $error("board_renderer: PITCH must not be smaller than CELL_PX");
    end

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [PW-1:0]   py_q, py_d;
    logic [PW-1:0]   px_q, px_d;
    logic [GW-1:0]   grid_q, grid_d;
    logic            cen_q, cen_d;
    logic [KW-1:0]   cidx_q, cidx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            plot_q, plot_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [2:0]      colour_q, colour_d;

    logic            load;
    logic            last_px, last_py, last_col, last_cell;
    logic [KW-1:0]   n_k;
    logic [CW-1:0]   n_row, n_col;
    logic [PW-1:0]   n_py, n_px;
    logic [KW-1:0]   pix_k;
    logic [CW-1:0]   pix_row, pix_col;
    logic [PW-1:0]   pix_py, pix_px;
    logic [GW-1:0]   src_grid;
    logic            src_cen;
    logic [KW-1:0]   src_cidx;
    logic [1:0]      pix_code;
    logic [2:0]      lut_colour;
    logic            pix_edge;
    logic [2:0]      pix_colour;
    logic [XW-1:0]   pix_x;
    logic [YW-1:0]   pix_y;

    // Step px fastest, then py, then the cell (tracking its row/column alongside k).
    // A start accepted from IDLE/DONE overrides this with pixel 0 of the live inputs.
    always_comb begin
        last_px   = (px_q == PW'(CELL_PX - 1));
        last_py   = (py_q == PW'(CELL_PX - 1));
        last_col  = (col_q == CW'(N - 1));
        last_cell = (k_q == KW'(NN - 1));
        n_k   = k_q;
        n_row = row_q;
        n_col = col_q;
        n_py  = py_q;
        n_px  = px_q;
        if (last_px) begin
            n_px = '0;
            if (last_py) begin
                n_py = '0;
                n_k  = k_q + 1'b1;
                if (last_col) begin
                    n_col = '0;
                    n_row = row_q + 1'b1;
                end else begin
                    n_col = col_q + 1'b1;
                end
            end else begin
                n_py = py_q + 1'b1;
            end
        end else begin
            n_px = px_q + 1'b1;
        end

        load = (state_q != ST_DRAW) && bus.start;
        if (load) begin
            pix_k    = '0;
            pix_row  = '0;
            pix_col  = '0;
            pix_py   = '0;
            pix_px   = '0;
            src_grid = bus.grid;
            src_cen  = bus.cursor_en;
            src_cidx = bus.cursor_idx;
        end else begin
            pix_k    = n_k;
            pix_row  = n_row;
            pix_col  = n_col;
            pix_py   = n_py;
            pix_px   = n_px;
            src_grid = grid_q;
            src_cen  = cen_q;
            src_cidx = cidx_q;
        end
        pix_code = src_grid[2 * (NN - 1 - int'(pix_k)) +: 2];
    end

    cell_colour_lut u_lut (
        .code   (pix_code),
        .colour (lut_colour)
    );

    always_comb begin
        pix_edge = (pix_px == '0) || (pix_px == PW'(CELL_PX - 1)) ||
                   (pix_py == '0) || (pix_py == PW'(CELL_PX - 1));
        if (src_cen && (pix_k == src_cidx) && pix_edge) begin
            pix_colour = COL_CURSOR;
        end else begin
            pix_colour = lut_colour;
        end
        pix_x = XW'(X0 + int'(pix_col) * PITCH + int'(pix_px));
        pix_y = YW'(Y0 + int'(pix_row) * PITCH + int'(pix_py));
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        row_d    = row_q;
        col_d    = col_q;
        py_d     = py_q;
        px_d     = px_q;
        grid_d   = grid_q;
        cen_d    = cen_q;
        cidx_d   = cidx_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        plot_d   = 1'b0;
        x_d      = '0;
        y_d      = '0;
        colour_d = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (load) begin
                    state_d = ST_DRAW;
                    grid_d  = bus.grid;
                    cen_d   = bus.cursor_en;
                    cidx_d  = bus.cursor_idx;
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                    py_d    = '0;
                    px_d    = '0;
                end
            end
            ST_DRAW: begin
                if (last_px && last_py && last_cell) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    k_d   = n_k;
                    row_d = n_row;
                    col_d = n_col;
                    py_d  = n_py;
                    px_d  = n_px;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The pixel at the counters' new position is emitted on the same edge they move.
        if (load || (state_q == ST_DRAW && state_d == ST_DRAW)) begin
            busy_d   = 1'b1;
            plot_d   = 1'b1;
            x_d      = pix_x;
            y_d      = pix_y;
            colour_d = pix_colour;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            row_q    <= '0;
            col_q    <= '0;
            py_q     <= '0;
            px_q     <= '0;
            grid_q   <= '0;
            cen_q    <= 1'b0;
            cidx_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            row_q    <= row_d;
            col_q    <= col_d;
            py_q     <= py_d;
            px_q     <= px_d;
            grid_q   <= grid_d;
            cen_q    <= cen_d;
            cidx_q   <= cidx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            plot_q   <= plot_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.plot       = plot_q;
    assign bus.x_out      = x_q;
    assign bus.y_out      = y_q;
    assign bus.colour_out = colour_q;

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer at default geometry (3x3 cells, 20 px squares, pitch 30).
// Each task drives one scenario and checks hand-computed pixels, counts and handshake timing.
module tb_board_renderer;

    localparam logic [17:0] GRID_EMPTY = 18'b00_00_00_00_00_00_00_00_00;
    localparam logic [17:0] GRID_CODES = 18'b01_00_00_00_11_00_00_00_10;
    localparam logic [17:0] GRID_ALLX  = 18'b10_10_10_10_10_10_10_10_10;

    logic clock = 1'b0;
    logic resetn;

    int total = 0;
    int bad   = 0;

    int       plot_cnt;
    int       cursor_cnt;
    int       busy_bad;
    int       first_cyc;
    bit       got_done;
    bit       done_ok;
    logic [7:0] first_x, last_x;
    logic [6:0] first_y, last_y;
    logic [2:0] first_c, last_c;
    logic [2:0] frame [256][128];

    always #5 clock = ~clock;

    board_renderer_if #(.N(3), .XW(8), .YW(7)) bus ();

    board_renderer #(
        .N(3), .CELL_PX(20), .PITCH(30), .X0(37), .Y0(7), .XW(8), .YW(7)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic start_sweep(input logic [17:0] g, input logic ce, input logic [3:0] ci);
        @(posedge clock);
        #1;
        bus.grid       = g;
        bus.cursor_en  = ce;
        bus.cursor_idx = ci;
        bus.start      = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    // Records the plot stream until done (bounded); optionally disturbs inputs mid-sweep
    // or raises start in the done cycle for a back-to-back sweep.
    task automatic collect(input bit restart_on_done, input int disturb_at);
        bit prev_plot;
        plot_cnt   = 0;
        cursor_cnt = 0;
        busy_bad   = 0;
        first_cyc  = -1;
        got_done   = 1'b0;
        done_ok    = 1'b0;
        prev_plot  = 1'b0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clock);
            if (disturb_at >= 0) begin
                bus.start = (plot_cnt == disturb_at);
                if (plot_cnt == disturb_at) begin
                    bus.grid       = GRID_ALLX;
                    bus.cursor_en  = 1'b1;
                    bus.cursor_idx = 4'd0;
                end
            end
            if (bus.plot === 1'b1) begin
                if (plot_cnt == 0) begin
                    first_cyc = cyc;
                    first_x   = bus.x_out;
                    first_y   = bus.y_out;
                    first_c   = bus.colour_out;
                end
                plot_cnt++;
                last_x = bus.x_out;
                last_y = bus.y_out;
                last_c = bus.colour_out;
                if (bus.busy !== 1'b1) busy_bad++;
                if (bus.colour_out === 3'b110) cursor_cnt++;
                frame[bus.x_out][bus.y_out] = bus.colour_out;
            end
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                done_ok  = prev_plot && (bus.plot === 1'b0) && (bus.busy === 1'b0);
                if (restart_on_done) bus.start = 1'b1;
                break;
            end
            prev_plot = (bus.plot === 1'b1);
        end
        bus.start = (restart_on_done && got_done);
    endtask

    task automatic test_reset();
        int idle_plots;
        resetn         = 1'b0;
        bus.start      = 1'b0;
        bus.grid       = GRID_EMPTY;
        bus.cursor_en  = 1'b0;
        bus.cursor_idx = 4'd0;
        repeat (3) @(negedge clock);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        total++; if (bus.plot !== 1'b0) begin bad++; $display("[TB] FAIL reset_plot: got %b expected 0", bus.plot); end
        total++; if (bus.x_out !== 8'd0) begin bad++; $display("[TB] FAIL reset_x: got %0d expected 0", bus.x_out); end
        total++; if (bus.y_out !== 7'd0) begin bad++; $display("[TB] FAIL reset_y: got %0d expected 0", bus.y_out); end
        total++; if (bus.colour_out !== 3'd0) begin bad++; $display("[TB] FAIL reset_colour: got %b expected 000", bus.colour_out); end
        resetn = 1'b1;
        idle_plots = 0;
        repeat (10) begin
            @(negedge clock);
            if (bus.plot !== 1'b0 || bus.busy !== 1'b0) idle_plots++;
        end
        total++; if (idle_plots !== 0) begin bad++; $display("[TB] FAIL idle_no_plot: got %0d active cycles expected 0", idle_plots); end
    endtask

    task automatic test_empty_sweep();
        start_sweep(GRID_EMPTY, 1'b0, 4'd0);
        collect(1'b0, -1);
        total++; if (plot_cnt !== 3600) begin bad++; $display("[TB] FAIL empty_count: got %0d expected 3600", plot_cnt); end
        total++; if (first_cyc !== 0) begin bad++; $display("[TB] FAIL empty_latency: got %0d expected 0", first_cyc); end
        total++; if (first_x !== 8'd37 || first_y !== 7'd7) begin bad++; $display("[TB] FAIL empty_first_xy: got (%0d,%0d) expected (37,7)", first_x, first_y); end
        total++; if (first_c !== 3'b111) begin bad++; $display("[TB] FAIL empty_first_colour: got %b expected 111", first_c); end
        total++; if (last_x !== 8'd116 || last_y !== 7'd86) begin bad++; $display("[TB] FAIL empty_last_xy: got (%0d,%0d) expected (116,86)", last_x, last_y); end
        total++; if (last_c !== 3'b111) begin bad++; $display("[TB] FAIL empty_last_colour: got %b expected 111", last_c); end
        total++; if (got_done !== 1'b1) begin bad++; $display("[TB] FAIL empty_done_seen: got %b expected 1", got_done); end
        total++; if (done_ok !== 1'b1) begin bad++; $display("[TB] FAIL empty_done_timing: got %b expected 1", done_ok); end
        total++; if (busy_bad !== 0) begin bad++; $display("[TB] FAIL empty_busy_during_plot: got %0d low cycles expected 0", busy_bad); end
        @(negedge clock);
        total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL empty_done_width: got %b expected 0", bus.done); end
    endtask

    task automatic test_codes();
        start_sweep(GRID_CODES, 1'b0, 4'd0);
        collect(1'b0, -1);
        total++; if (plot_cnt !== 3600) begin bad++; $display("[TB] FAIL codes_count: got %0d expected 3600", plot_cnt); end
        total++; if (frame[37][7] !== 3'b011) begin bad++; $display("[TB] FAIL codes_cell0_O: got %b expected 011", frame[37][7]); end
        total++; if (frame[97][67] !== 3'b101) begin bad++; $display("[TB] FAIL codes_cell8_X: got %b expected 101", frame[97][67]); end
        total++; if (frame[67][37] !== 3'b000) begin bad++; $display("[TB] FAIL codes_cell4_rsvd: got %b expected 000", frame[67][37]); end
        total++; if (frame[67][7] !== 3'b111) begin bad++; $display("[TB] FAIL codes_cell1_empty: got %b expected 111", frame[67][7]); end
        total++; if (frame[56][26] !== 3'b011) begin bad++; $display("[TB] FAIL codes_cell0_corner: got %b expected 011", frame[56][26]); end
    endtask

    task automatic test_cursor();
        start_sweep(GRID_EMPTY, 1'b1, 4'd4);
        collect(1'b0, -1);
        total++; if (frame[67][37] !== 3'b110) begin bad++; $display("[TB] FAIL cursor_topleft: got %b expected 110", frame[67][37]); end
        total++; if (frame[86][56] !== 3'b110) begin bad++; $display("[TB] FAIL cursor_botright: got %b expected 110", frame[86][56]); end
        total++; if (frame[68][38] !== 3'b111) begin bad++; $display("[TB] FAIL cursor_interior: got %b expected 111", frame[68][38]); end
        total++; if (frame[37][7] !== 3'b111) begin bad++; $display("[TB] FAIL cursor_other_cell: got %b expected 111", frame[37][7]); end
        total++; if (cursor_cnt !== 76) begin bad++; $display("[TB] FAIL cursor_ring_count: got %0d expected 76", cursor_cnt); end
        start_sweep(GRID_EMPTY, 1'b1, 4'd9);
        collect(1'b0, -1);
        total++; if (cursor_cnt !== 0) begin bad++; $display("[TB] FAIL cursor_out_of_range: got %0d expected 0", cursor_cnt); end
    endtask

    task automatic test_snapshot();
        start_sweep(GRID_CODES, 1'b0, 4'd0);
        collect(1'b0, 500);
        total++; if (plot_cnt !== 3600) begin bad++; $display("[TB] FAIL snap_count: got %0d expected 3600", plot_cnt); end
        total++; if (cursor_cnt !== 0) begin bad++; $display("[TB] FAIL snap_no_cursor: got %0d expected 0", cursor_cnt); end
        total++; if (frame[37][7] !== 3'b011) begin bad++; $display("[TB] FAIL snap_cell0: got %b expected 011", frame[37][7]); end
        total++; if (frame[67][37] !== 3'b000) begin bad++; $display("[TB] FAIL snap_cell4: got %b expected 000", frame[67][37]); end
        total++; if (frame[67][7] !== 3'b111) begin bad++; $display("[TB] FAIL snap_cell1: got %b expected 111", frame[67][7]); end
        total++; if (done_ok !== 1'b1) begin bad++; $display("[TB] FAIL snap_done_timing: got %b expected 1", done_ok); end
    endtask

    task automatic test_back_to_back();
        start_sweep(GRID_EMPTY, 1'b0, 4'd0);
        bus.grid = GRID_CODES;
        collect(1'b1, -1);
        total++; if (plot_cnt !== 3600) begin bad++; $display("[TB] FAIL b2b_first_count: got %0d expected 3600", plot_cnt); end
        total++; if (last_c !== 3'b111) begin bad++; $display("[TB] FAIL b2b_first_last_colour: got %b expected 111", last_c); end
        @(negedge clock);
        bus.start = 1'b0;
        total++; if (bus.plot !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_restart_plot: got plot=%b busy=%b expected 1/1", bus.plot, bus.busy); end
        total++; if (bus.x_out !== 8'd37 || bus.y_out !== 7'd7) begin bad++; $display("[TB] FAIL b2b_restart_xy: got (%0d,%0d) expected (37,7)", bus.x_out, bus.y_out); end
        total++; if (bus.colour_out !== 3'b011) begin bad++; $display("[TB] FAIL b2b_restart_colour: got %b expected 011", bus.colour_out); end
        collect(1'b0, -1);
        total++; if (plot_cnt !== 3599) begin bad++; $display("[TB] FAIL b2b_second_count: got %0d expected 3599", plot_cnt); end
        total++; if (frame[97][67] !== 3'b101) begin bad++; $display("[TB] FAIL b2b_second_cell8: got %b expected 101", frame[97][67]); end
        total++; if (done_ok !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second_done: got %b expected 1", done_ok); end
    endtask

    task automatic test_reset_mid_sweep();
        int seen;
        int stray;
        start_sweep(GRID_EMPTY, 1'b0, 4'd0);
        seen = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clock);
            if (bus.plot === 1'b1) seen++;
            if (seen == 100) break;
        end
        total++; if (seen !== 100) begin bad++; $display("[TB] FAIL mid_reach_100: got %0d expected 100", seen); end
        resetn = 1'b0;
        #1;
        total++; if (bus.plot !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_now: got plot=%b busy=%b expected 0/0", bus.plot, bus.busy); end
        total++; if (bus.x_out !== 8'd0 || bus.y_out !== 7'd0 || bus.colour_out !== 3'd0) begin bad++; $display("[TB] FAIL mid_reset_pixel: got (%0d,%0d,%b) expected (0,0,000)", bus.x_out, bus.y_out, bus.colour_out); end
        stray = 0;
        repeat (4) begin
            @(negedge clock);
            if (bus.done !== 1'b0 || bus.plot !== 1'b0) stray++;
        end
        resetn = 1'b1;
        repeat (6) begin
            @(negedge clock);
            if (bus.done !== 1'b0 || bus.plot !== 1'b0) stray++;
        end
        total++; if (stray !== 0) begin bad++; $display("[TB] FAIL mid_no_done: got %0d active cycles expected 0", stray); end
        start_sweep(GRID_EMPTY, 1'b0, 4'd0);
        collect(1'b0, -1);
        total++; if (first_x !== 8'd37 || first_y !== 7'd7 || first_cyc !== 0) begin bad++; $display("[TB] FAIL mid_restart_first: got (%0d,%0d) at %0d expected (37,7) at 0", first_x, first_y, first_cyc); end
        total++; if (plot_cnt !== 3600) begin bad++; $display("[TB] FAIL mid_restart_count: got %0d expected 3600", plot_cnt); end
    endtask

    initial begin
        $display("[TB] board_renderer bench starting");
        test_reset();
        test_empty_sweep();
        test_codes();
        test_cursor();
        test_snapshot();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
